// File: rtl/dcs_result_packer.sv
// Result packer for the DCSformer attention core. It captures 8-word bursts into ping-pong banks,
// tracks the argmax, derives a power-of-two scale and streams the quantized bytes over valid/ready.
module dcs_result_packer #(
    parameter int N_WORDS = 8,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [IN_W-1:0]            in_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_last,
    output logic [$clog2(N_WORDS)-1:0] out_idx,
    output logic [$clog2(IN_W)-1:0]    out_shift,
    output logic                       overflow
);
    localparam int IW = $clog2(N_WORDS);
    localparam int SW = $clog2(IN_W);
    localparam logic [IW-1:0] LAST_W = IW'(N_WORDS - 1);
    localparam logic [IW-1:0] ONE_W  = IW'(1);

    // Right-shift that brings the most-significant 1 of v down to bit OUT_W-1.
    function automatic logic [SW-1:0] calc_shift(input logic [IN_W-1:0] v);
        logic [SW-1:0] msb;
        msb = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (v[i]) msb = SW'(i);
            else      msb = msb;
        end
        if (msb >= SW'(OUT_W - 1)) return msb - SW'(OUT_W - 1);
        else                       return '0;
    endfunction

    logic [IN_W-1:0] mem_r [2][N_WORDS];
    logic [IW-1:0]   bank_idx_r   [2];
    logic [SW-1:0]   bank_shift_r [2];
    logic [1:0]      full_r;
    logic            wr_bank_r, rd_bank_r, drop_r;
    logic [IW-1:0]   wr_cnt_r, rd_cnt_r, idx_r;
    logic [IN_W-1:0] max_r;

    logic            xfer_s, release_s, first_s, tgt_busy_s, drop_now_s, dropping_s;
    logic            we_s, complete_s, rd_bank_nxt_s, valid_nxt_s;
    logic [1:0]      full_nxt_s;
    logic [IW-1:0]   rd_cnt_nxt_s, idx_cand_s, idx_sel_s;
    logic [IN_W-1:0] max_cand_s, word_sel_s;
    logic [SW-1:0]   shift_cand_s, shift_sel_s;

    // Next-state decode for both sides; the dropped-frame decision sees a same-cycle release.
    always_comb begin
        xfer_s     = out_valid & out_ready;
        release_s  = xfer_s & (rd_cnt_r == LAST_W);
        first_s    = in_valid & (wr_cnt_r == '0);
        tgt_busy_s = full_r[wr_bank_r] & ~(release_s & (rd_bank_r == wr_bank_r));
        drop_now_s = first_s & tgt_busy_s;
        if (first_s) dropping_s = drop_now_s;
        else         dropping_s = drop_r;
        we_s       = in_valid & ~dropping_s;
        complete_s = we_s & (wr_cnt_r == LAST_W);

        // Strict compare so that ties keep the lowest index.
        if ((wr_cnt_r == '0) || (in_data > max_r)) begin
            max_cand_s = in_data;
            idx_cand_s = wr_cnt_r;
        end else begin
            max_cand_s = max_r;
            idx_cand_s = idx_r;
        end
        shift_cand_s = calc_shift(max_cand_s);

        full_nxt_s = full_r;
        if (release_s)  full_nxt_s[rd_bank_r] = 1'b0;
        else            full_nxt_s = full_nxt_s;
        if (complete_s) full_nxt_s[wr_bank_r] = 1'b1;
        else            full_nxt_s = full_nxt_s;

        if (release_s) begin
            rd_bank_nxt_s = ~rd_bank_r;
            rd_cnt_nxt_s  = '0;
        end else if (xfer_s) begin
            rd_bank_nxt_s = rd_bank_r;
            rd_cnt_nxt_s  = rd_cnt_r + ONE_W;
        end else begin
            rd_bank_nxt_s = rd_bank_r;
            rd_cnt_nxt_s  = rd_cnt_r;
        end

        // Forward the frame being completed this cycle so the output registers see it immediately.
        if (complete_s && (wr_bank_r == rd_bank_nxt_s)) begin
            idx_sel_s   = idx_cand_s;
            shift_sel_s = shift_cand_s;
        end else begin
            idx_sel_s   = bank_idx_r[rd_bank_nxt_s];
            shift_sel_s = bank_shift_r[rd_bank_nxt_s];
        end
        if (we_s && (wr_bank_r == rd_bank_nxt_s) && (wr_cnt_r == rd_cnt_nxt_s)) word_sel_s = in_data;
        else word_sel_s = mem_r[rd_bank_nxt_s][rd_cnt_nxt_s];
        valid_nxt_s = full_nxt_s[rd_bank_nxt_s];
    end

    // Frame storage; contents are only meaningful while the bank-full flag is set.
    always_ff @(posedge clk) begin
        if (we_s) mem_r[wr_bank_r][wr_cnt_r] <= in_data;
    end

    // Control state and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            drop_r    <= 1'b0;
            wr_cnt_r  <= '0;
            rd_cnt_r  <= '0;
            idx_r     <= '0;
            max_r     <= '0;
            for (int b = 0; b < 2; b++) begin
                bank_idx_r[b]   <= '0;
                bank_shift_r[b] <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_shift <= '0;
            overflow  <= 1'b0;
        end else begin
            full_r    <= full_nxt_s;
            rd_bank_r <= rd_bank_nxt_s;
            rd_cnt_r  <= rd_cnt_nxt_s;
            overflow  <= drop_now_s;
            if (first_s) drop_r <= drop_now_s;
            if (in_valid) wr_cnt_r <= (wr_cnt_r == LAST_W) ? '0 : wr_cnt_r + ONE_W;
            if (we_s) begin
                max_r <= max_cand_s;
                idx_r <= idx_cand_s;
            end
            if (complete_s) begin
                bank_idx_r[wr_bank_r]   <= idx_cand_s;
                bank_shift_r[wr_bank_r] <= shift_cand_s;
                wr_bank_r               <= ~wr_bank_r;
            end
            out_valid <= valid_nxt_s;
            out_data  <= valid_nxt_s ? OUT_W'(word_sel_s >> shift_sel_s) : '0;
            out_last  <= valid_nxt_s & (rd_cnt_nxt_s == LAST_W);
            out_idx   <= valid_nxt_s ? idx_sel_s : '0;
            out_shift <= valid_nxt_s ? shift_sel_s : '0;
        end
    end
endmodule
